// File: rtl/mef_vedacao_pkg.sv
// Shared types and width helpers for the capping stage that follows the filling FSM.
package mef_vedacao_pkg;

   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      TRANSPORTE = 2'd1,
      VEDANDO    = 2'd2,
      LIBERA     = 2'd3
   } estado_veda_t;

   function automatic int larguraContagem(input int lote);
      return $clog2(lote);
   endfunction

   function automatic int larguraEstoque(input int estoqueMax);
      return $clog2(estoqueMax + 1);
   endfunction

   // A one-cycle capping time still needs a 1-bit timer.
   function automatic int larguraTimer(input int tempoVeda);
      return ($clog2(tempoVeda) > 1) ? $clog2(tempoVeda) : 1;
   endfunction

endpackage

// File: rtl/mef_vedacao_if.sv
// Line-side signal bundle of the capping stage: the controller drives the sensors, the stage drives the actuators.
interface mef_vedacao_if #(
   parameter int LOTE        = 6,
   parameter int ESTOQUE_MAX = 15
);
   import mef_vedacao_pkg::*;

   localparam int WC = larguraContagem(LOTE);
   localparam int WE = larguraEstoque(ESTOQUE_MAX);

   logic          Start;
   logic          Pronto;
   logic          GarrafaV;
   logic          Repor;
   logic          Motor;
   logic          Vedando;
   logic          Liberado;
   logic          Lote;
   logic [WC-1:0] Contagem;
   logic [WE-1:0] Estoque;
   logic          AlarmeTampa;

   modport master (
      output Start, Pronto, GarrafaV, Repor,
      input  Motor, Vedando, Liberado, Lote, Contagem, Estoque, AlarmeTampa
   );

   modport slave (
      input  Start, Pronto, GarrafaV, Repor,
      output Motor, Vedando, Liberado, Lote, Contagem, Estoque, AlarmeTampa
   );

endinterface

// File: rtl/mef_vedacao_temporizador.sv
// Loadable down-counter timing the capping actuator; stops at zero and flags it.
module temporizador_veda #(
   parameter int LARGURA = 2
) (
   input  logic               CK,
   input  logic               nReset,
   input  logic               carregar,
   input  logic               decrementar,
   input  logic [LARGURA-1:0] valor,
   output logic               zero
);

   logic [LARGURA-1:0] contador;

   // Load has priority over counting down; the count saturates at zero.
   always_ff @(posedge CK) begin
      if (!nReset) begin
         contador <= '0;
      end else if (carregar) begin
         contador <= valor;
      end else if (decrementar && (contador != '0)) begin
         contador <= contador - LARGURA'(1);
      end else begin
         contador <= contador;
      end
   end

   assign zero = (contador == '0);

endmodule

// File: rtl/mef_vedacao.sv
// Capping stage: moves a filled bottle to the capper, seals it for TEMPO_VEDA cycles,
// releases it, and keeps pack count and cap stock.
module mef_vedacao
   import mef_vedacao_pkg::*;
#(
   parameter int TEMPO_VEDA  = 4,
   parameter int LOTE        = 6,
   parameter int ESTOQUE_MAX = 15
) (
   input logic           CK,
   input logic           nReset,
   mef_vedacao_if.slave  bus
);

   localparam int WC = larguraContagem(LOTE);
   localparam int WE = larguraEstoque(ESTOQUE_MAX);
   localparam int WT = larguraTimer(TEMPO_VEDA);

   estado_veda_t  estado;
   logic [WC-1:0] contagem;
   logic [WE-1:0] estoque;
   logic          liberado;
   logic          lote;
   logic          timerZero;
   logic          carregaTimer;
   logic          fimVeda;

   assign carregaTimer = (estado == TRANSPORTE) && bus.Start && bus.GarrafaV;
   assign fimVeda      = (estado == VEDANDO) && timerZero;

   temporizador_veda #(
      .LARGURA (WT)
   ) uTimer (
      .CK          (CK),
      .nReset      (nReset),
      .carregar    (carregaTimer),
      .decrementar (estado == VEDANDO),
      .valor       (WT'(TEMPO_VEDA - 1)),
      .zero        (timerZero)
   );

   // Sequencing FSM plus the pack counter, the stock counter and the release pulses.
   always_ff @(posedge CK) begin
      if (!nReset) begin
         estado   <= OCIOSO;
         contagem <= '0;
         estoque  <= WE'(ESTOQUE_MAX);
         liberado <= 1'b0;
         lote     <= 1'b0;
      end else begin
         liberado <= 1'b0;
         lote     <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (bus.Start && bus.Pronto && (estoque != '0)) begin
                  estado <= TRANSPORTE;
               end
            end
            TRANSPORTE: begin
               if (bus.Start && bus.GarrafaV) begin
                  estado <= VEDANDO;
               end
            end
            VEDANDO: begin
               if (timerZero) begin
                  estado   <= LIBERA;
                  liberado <= 1'b1;
                  if (contagem == WC'(LOTE - 1)) begin
                     contagem <= '0;
                     lote     <= 1'b1;
                  end else begin
                     contagem <= contagem + WC'(1);
                  end
               end
            end
            LIBERA: begin
               if (bus.Start && !bus.GarrafaV) begin
                  estado <= OCIOSO;
               end
            end
            default: begin
               estado <= OCIOSO;
            end
         endcase

         // A reload in the same cycle as a consumption leaves the stock full.
         if (bus.Repor) begin
            estoque <= WE'(ESTOQUE_MAX);
         end else if (fimVeda && (estoque != '0)) begin
            estoque <= estoque - WE'(1);
         end else begin
            estoque <= estoque;
         end
      end
   end

   assign bus.Motor       = ((estado == TRANSPORTE) || (estado == LIBERA)) && bus.Start;
   assign bus.Vedando     = (estado == VEDANDO);
   assign bus.Liberado    = liberado;
   assign bus.Lote        = lote;
   assign bus.Contagem    = contagem;
   assign bus.Estoque     = estoque;
   assign bus.AlarmeTampa = (estoque == '0);

endmodule

// File: tb/tb_mef_vedacao.sv
// Directed bench for mef_vedacao: a vector table for one bottle, then hand-written multi-cycle sequences.
module tb_mef_vedacao;

   logic CK;
   logic nReset;
   int   checks;
   int   errors;

   mef_vedacao_if #(.LOTE(6), .ESTOQUE_MAX(15)) bus ();

   mef_vedacao #(
      .TEMPO_VEDA  (4),
      .LOTE        (6),
      .ESTOQUE_MAX (15)
   ) dut (
      .CK     (CK),
      .nReset (nReset),
      .bus    (bus)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   typedef struct {
      logic s, p, g, r;
      logic motor, ved, lib, lote;
      int   cont, est;
      logic alarme;
   } vetor_t;

   vetor_t tab [0:10];

   logic gOk;
   logic gLote;
   logic gAlarme;
   int   gCont;
   int   gEst;

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      checks++;
      if (atual !== esperado) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #2;
   endtask

   task automatic pulsoReset();
      nReset = 1'b0;
      tick();
      nReset = 1'b1;
   endtask

   // Runs one bottle from OCIOSO with the sensor clearing right after release.
   task automatic umaGarrafa();
      gOk = 1'b0;
      gLote = 1'b0;
      gAlarme = 1'b0;
      gCont = -1;
      gEst = -1;
      bus.Start = 1'b1;
      bus.Pronto = 1'b1;
      bus.GarrafaV = 1'b0;
      tick();
      bus.Pronto = 1'b0;
      bus.GarrafaV = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         #1;
         if (bus.Liberado === 1'b1) begin
            gOk = 1'b1;
            gLote = bus.Lote;
            gAlarme = bus.AlarmeTampa;
            gCont = int'(bus.Contagem);
            gEst = int'(bus.Estoque);
            break;
         end
      end
      bus.GarrafaV = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      nReset = 1'b0;
      bus.Start = 1'b0;
      bus.Pronto = 1'b0;
      bus.GarrafaV = 1'b0;
      bus.Repor = 1'b0;

      //                s     p     g     r     motor ved   lib   lote  cont est alarme
      tab[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 15, 1'b0};
      tab[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 14, 1'b0};
      tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 14, 1'b0};
      tab[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14, 1'b0};

      tick();
      tick();
      nReset = 1'b1;
      #1;
      chk("rst_motor", bus.Motor, 1'b0);
      chk("rst_vedando", bus.Vedando, 1'b0);
      chk("rst_liberado", bus.Liberado, 1'b0);
      chk("rst_lote", bus.Lote, 1'b0);
      chk("rst_contagem", bus.Contagem, 0);
      chk("rst_estoque", bus.Estoque, 15);
      chk("rst_alarme", bus.AlarmeTampa, 1'b0);

      // Single bottle, one vector per cycle.
      for (int i = 0; i <= 10; i++) begin
         bus.Start = tab[i].s;
         bus.Pronto = tab[i].p;
         bus.GarrafaV = tab[i].g;
         bus.Repor = tab[i].r;
         #1;
         chk($sformatf("v%0d_motor", i), bus.Motor, tab[i].motor);
         chk($sformatf("v%0d_vedando", i), bus.Vedando, tab[i].ved);
         chk($sformatf("v%0d_liberado", i), bus.Liberado, tab[i].lib);
         chk($sformatf("v%0d_lote", i), bus.Lote, tab[i].lote);
         chk($sformatf("v%0d_contagem", i), bus.Contagem, tab[i].cont);
         chk($sformatf("v%0d_estoque", i), bus.Estoque, tab[i].est);
         chk($sformatf("v%0d_alarme", i), bus.AlarmeTampa, tab[i].alarme);
         tick();
      end

      // Pack wrap then stock exhaustion from a fresh reset.
      pulsoReset();
      for (int b = 1; b <= 15; b++) begin
         umaGarrafa();
         chk($sformatf("b%0d_ok", b), gOk, 1'b1);
         chk($sformatf("b%0d_lote", b), gLote, (b % 6) == 0);
         chk($sformatf("b%0d_contagem", b), gCont, b % 6);
         chk($sformatf("b%0d_estoque", b), gEst, 15 - b);
         chk($sformatf("b%0d_alarme", b), gAlarme, b == 15);
      end

      bus.Start = 1'b1;
      bus.Pronto = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("vazio_motor", bus.Motor, 1'b0);
         chk("vazio_vedando", bus.Vedando, 1'b0);
         tick();
      end
      bus.Pronto = 1'b0;
      bus.Repor = 1'b1;
      tick();
      bus.Repor = 1'b0;
      #1;
      chk("repor_estoque", bus.Estoque, 15);
      chk("repor_alarme", bus.AlarmeTampa, 1'b0);
      umaGarrafa();
      chk("pos_repor_ok", gOk, 1'b1);
      chk("pos_repor_estoque", gEst, 14);
      chk("pos_repor_contagem", gCont, 4);

      // Reload during the last capping cycle beats the decrement.
      bus.Start = 1'b1;
      bus.Pronto = 1'b1;
      tick();
      bus.Pronto = 1'b0;
      bus.GarrafaV = 1'b1;
      tick();
      tick();
      tick();
      tick();
      bus.Repor = 1'b1;
      #1;
      chk("simul_vedando", bus.Vedando, 1'b1);
      tick();
      bus.Repor = 1'b0;
      #1;
      chk("simul_liberado", bus.Liberado, 1'b1);
      chk("simul_estoque", bus.Estoque, 15);
      chk("simul_contagem", bus.Contagem, 5);
      bus.GarrafaV = 1'b0;
      tick();

      // Pause in TRANSPORTE, then Start dropped during capping.
      bus.Start = 1'b1;
      bus.Pronto = 1'b1;
      tick();
      bus.Pronto = 1'b0;
      bus.Start = 1'b0;
      bus.GarrafaV = 1'b1;
      #1;
      chk("pausa_motor", bus.Motor, 1'b0);
      tick();
      #1;
      chk("pausa_motor2", bus.Motor, 1'b0);
      chk("pausa_vedando", bus.Vedando, 1'b0);
      bus.Start = 1'b1;
      #1;
      chk("pausa_retoma", bus.Motor, 1'b1);
      tick();
      bus.Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("pausa_veda", bus.Vedando, 1'b1);
         tick();
      end
      #1;
      chk("pausa_liberado", bus.Liberado, 1'b1);
      chk("pausa_lote", bus.Lote, 1'b1);
      chk("pausa_libera_motor", bus.Motor, 1'b0);
      bus.GarrafaV = 1'b0;
      tick();
      #1;
      chk("pausa_liberado_unico", bus.Liberado, 1'b0);
      chk("pausa_libera_motor2", bus.Motor, 1'b0);
      bus.Start = 1'b1;
      #1;
      chk("pausa_libera_retoma", bus.Motor, 1'b1);
      tick();
      #1;
      chk("pausa_ocioso_motor", bus.Motor, 1'b0);
      chk("pausa_estoque", bus.Estoque, 14);

      // Reset in the second capping cycle.
      umaGarrafa();
      chk("pre_rst_contagem", gCont, 1);
      chk("pre_rst_estoque", gEst, 13);
      bus.Start = 1'b1;
      bus.Pronto = 1'b1;
      tick();
      bus.Pronto = 1'b0;
      bus.GarrafaV = 1'b1;
      tick();
      tick();
      #1;
      chk("mid_vedando", bus.Vedando, 1'b1);
      nReset = 1'b0;
      bus.GarrafaV = 1'b0;
      tick();
      nReset = 1'b1;
      #1;
      chk("mid_rst_vedando", bus.Vedando, 1'b0);
      chk("mid_rst_motor", bus.Motor, 1'b0);
      chk("mid_rst_contagem", bus.Contagem, 0);
      chk("mid_rst_estoque", bus.Estoque, 15);
      chk("mid_rst_alarme", bus.AlarmeTampa, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("mid_rst_liberado", bus.Liberado, 1'b0);
         chk("mid_rst_lote", bus.Lote, 1'b0);
         chk("mid_rst_ocioso", bus.Motor, 1'b0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
